// File: rtl/id_stage_pipe_pkg.sv
// Shared opcodes, instruction field helpers and decode payload for the ID stage.
package id_stage_pipe_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned ALUOP_W = 4;

    localparam logic [OPC_W-1:0] OP_LW   = 4'h8;
    localparam logic [OPC_W-1:0] OP_SW   = 4'h9;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'hA;
    localparam logic [OPC_W-1:0] OP_BR   = 4'hB;
    localparam logic [OPC_W-1:0] OP_JR   = 4'hC;
    localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

    // Instruction layout, high to low: opcode | rd | rs | rt
    function automatic int unsigned f_instr_w(input int unsigned reg_aw);
        return OPC_W + 3 * reg_aw;
    endfunction

    function automatic int unsigned f_rd_lsb(input int unsigned reg_aw);
        return 2 * reg_aw;
    endfunction

    function automatic int unsigned f_rs_lsb(input int unsigned reg_aw);
        return reg_aw;
    endfunction

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               mem_rd;
        logic               mem_wr;
        logic               saw_br;
        logic               saw_j;
        logic               hlt;
        logic               rd1_en;
        logic               rd2_en;
        logic               wr_en;
    } ctrl_t;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } halt_state_e;

endpackage

// File: rtl/id_stage_pipe_if.sv
// Bus between IF/ID, writeback and EX as seen by the decode stage.
interface id_stage_pipe_if
    import id_stage_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
);
    localparam int unsigned INSTR_W = f_instr_w(REG_AW);

    logic [INSTR_W-1:0] i_instr;
    logic               i_instrValid;
    logic               i_flush;
    logic               i_hlt;
    logic               i_Z;
    logic               i_wrEn;
    logic [REG_AW-1:0]  i_wrReg;
    logic [DATA_W-1:0]  i_wrData;

    logic               o_stall;
    logic               o_valid;
    logic [DATA_W-1:0]  o_port0;
    logic [DATA_W-1:0]  o_port1;
    logic [REG_AW-1:0]  o_rdReg1;
    logic [REG_AW-1:0]  o_rdReg2;
    logic [REG_AW-1:0]  o_wrReg;
    logic               o_rdReg1En;
    logic               o_rdReg2En;
    logic               o_wrRegEn;
    logic [ALUOP_W-1:0] o_aluOp;
    logic [REG_AW-1:0]  o_shAmt;
    logic               o_aluSrc;
    logic               o_memRd;
    logic               o_memWr;
    logic               o_mem2reg;
    logic               o_sawBr;
    logic               o_sawJ;
    logic               o_hlt;

    modport master (
        output i_instr, i_instrValid, i_flush, i_hlt, i_Z, i_wrEn, i_wrReg, i_wrData,
        input  o_stall, o_valid, o_port0, o_port1, o_rdReg1, o_rdReg2, o_wrReg,
               o_rdReg1En, o_rdReg2En, o_wrRegEn, o_aluOp, o_shAmt, o_aluSrc,
               o_memRd, o_memWr, o_mem2reg, o_sawBr, o_sawJ, o_hlt
    );

    modport slave (
        input  i_instr, i_instrValid, i_flush, i_hlt, i_Z, i_wrEn, i_wrReg, i_wrData,
        output o_stall, o_valid, o_port0, o_port1, o_rdReg1, o_rdReg2, o_wrReg,
               o_rdReg1En, o_rdReg2En, o_wrRegEn, o_aluOp, o_shAmt, o_aluSrc,
               o_memRd, o_memWr, o_mem2reg, o_sawBr, o_sawJ, o_hlt
    );

endinterface

// File: rtl/id_stage_pipe_regfile.sv
// Two-read, one-write register file; R0 hardwired to zero, contents not reset.
// ID_WR_BYPASS_EN: a same-cycle write to a read address is forwarded to that port.
module id_regfile #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic              i_clk,
    input  logic [REG_AW-1:0] i_rdAddr0,
    input  logic [REG_AW-1:0] i_rdAddr1,
    output logic [DATA_W-1:0] o_rdData0_c,
    output logic [DATA_W-1:0] o_rdData1_c,
    input  logic              i_wrEn,
    input  logic [REG_AW-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData
);

    localparam int unsigned DEPTH = 1 << REG_AW;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr;

    assign w_wr = i_wrEn && (i_wrAddr != '0);

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    always_comb begin
        o_rdData0_c = (i_rdAddr0 == '0) ? '0 : r_mem[i_rdAddr0];
        o_rdData1_c = (i_rdAddr1 == '0) ? '0 : r_mem[i_rdAddr1];
`ifdef ID_WR_BYPASS_EN
        if (w_wr && (i_wrAddr == i_rdAddr0)) o_rdData0_c = i_wrData;
        if (w_wr && (i_wrAddr == i_rdAddr1)) o_rdData1_c = i_wrData;
`endif
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction decode stage: decode, operand read, load-use stall, flush, ID/EX register.
// ID_WR_BYPASS_EN selects write-through reads; otherwise a writeback/read clash stalls one cycle.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic            i_clk,
    input  logic            i_nRst,
    id_stage_pipe_if.slave  id_bus
);

    localparam int unsigned INSTR_W = f_instr_w(REG_AW);
    localparam int unsigned RD_LSB  = f_rd_lsb(REG_AW);
    localparam int unsigned RS_LSB  = f_rs_lsb(REG_AW);

    logic [OPC_W-1:0]  w_opc;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_src2;
    ctrl_t             w_ctrl;
    logic [DATA_W-1:0] w_rdData0;
    logic [DATA_W-1:0] w_rdData1;
    logic              w_live;
    logic              w_luHit;
    logic              w_wbHit;
    logic              w_stall_c;
    logic              w_bubble;
    logic              w_halted_c;

    halt_state_e       r_state;
    halt_state_e       w_stateNxt;

    logic              r_valid;
    ctrl_t             r_ctrl;
    logic [DATA_W-1:0] r_port0;
    logic [DATA_W-1:0] r_port1;
    logic [REG_AW-1:0] r_rdReg1;
    logic [REG_AW-1:0] r_rdReg2;
    logic [REG_AW-1:0] r_wrReg;
    logic [REG_AW-1:0] r_shAmt;

    assign w_opc  = id_bus.i_instr[INSTR_W-1 -: OPC_W];
    assign w_rd   = id_bus.i_instr[RD_LSB +: REG_AW];
    assign w_rs   = id_bus.i_instr[RS_LSB +: REG_AW];
    assign w_rt   = id_bus.i_instr[REG_AW-1:0];
    // Stores read their data register through the rd field
    assign w_src2 = (w_opc == OP_SW) ? w_rd : w_rt;

    // Opcode decode
    always_comb begin
        w_ctrl = '0;
        if (!w_opc[OPC_W-1]) begin
            w_ctrl.alu_op = w_opc;
            w_ctrl.rd1_en = 1'b1;
            w_ctrl.rd2_en = 1'b1;
            w_ctrl.wr_en  = 1'b1;
        end else begin
            case (w_opc)
                OP_LW: begin
                    w_ctrl.mem_rd  = 1'b1;
                    w_ctrl.alu_src = 1'b1;
                    w_ctrl.rd1_en  = 1'b1;
                    w_ctrl.wr_en   = 1'b1;
                end
                OP_SW: begin
                    w_ctrl.mem_wr  = 1'b1;
                    w_ctrl.alu_src = 1'b1;
                    w_ctrl.rd1_en  = 1'b1;
                    w_ctrl.rd2_en  = 1'b1;
                end
                OP_ADDI: begin
                    w_ctrl.alu_src = 1'b1;
                    w_ctrl.rd1_en  = 1'b1;
                    w_ctrl.wr_en   = 1'b1;
                end
                OP_BR:   w_ctrl.saw_br = id_bus.i_Z;
                OP_JR: begin
                    w_ctrl.saw_j  = 1'b1;
                    w_ctrl.rd1_en = 1'b1;
                end
                OP_HLT:  w_ctrl.hlt = 1'b1;
                default: w_ctrl = '0;
            endcase
        end
    end

    id_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .i_clk       (i_clk),
        .i_rdAddr0   (w_rs),
        .i_rdAddr1   (w_src2),
        .o_rdData0_c (w_rdData0),
        .o_rdData1_c (w_rdData1),
        .i_wrEn      (id_bus.i_wrEn),
        .i_wrAddr    (id_bus.i_wrReg),
        .i_wrData    (id_bus.i_wrData)
    );

    // Hazards only matter for an instruction that will actually be issued
    assign w_live  = id_bus.i_instrValid && !id_bus.i_flush;
    assign w_luHit = r_valid && r_ctrl.mem_rd && (r_wrReg != '0) &&
                     ((w_ctrl.rd1_en && (w_rs == r_wrReg)) ||
                      (w_ctrl.rd2_en && (w_src2 == r_wrReg)));
`ifdef ID_WR_BYPASS_EN
    assign w_wbHit = 1'b0;
`else
    assign w_wbHit = id_bus.i_wrEn && (id_bus.i_wrReg != '0) &&
                     ((w_ctrl.rd1_en && (w_rs == id_bus.i_wrReg)) ||
                      (w_ctrl.rd2_en && (w_src2 == id_bus.i_wrReg)));
`endif
    assign w_stall_c = w_live && (w_luHit || w_wbHit);

    // Halt tracking: once a valid HLT is visible, only bubbles issue until reset
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) r_state <= ST_RUN;
        else         r_state <= w_stateNxt;
    end

    always_comb begin
        w_stateNxt = r_state;
        w_halted_c = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (r_valid && r_ctrl.hlt) begin
                    w_stateNxt = ST_HALTED;
                    w_halted_c = 1'b1;
                end
            end
            ST_HALTED: w_halted_c = 1'b1;
            default:   w_stateNxt = ST_RUN;
        endcase
    end

    assign w_bubble = id_bus.i_flush || w_stall_c || !id_bus.i_instrValid || w_halted_c;

    // ID/EX pipeline register
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_valid  <= 1'b0;
            r_ctrl   <= '0;
            r_port0  <= '0;
            r_port1  <= '0;
            r_rdReg1 <= '0;
            r_rdReg2 <= '0;
            r_wrReg  <= '0;
            r_shAmt  <= '0;
        end else if (!id_bus.i_hlt) begin
            if (w_bubble) begin
                r_valid  <= 1'b0;
                r_ctrl   <= '0;
                r_port0  <= '0;
                r_port1  <= '0;
                r_rdReg1 <= '0;
                r_rdReg2 <= '0;
                r_wrReg  <= '0;
                r_shAmt  <= '0;
            end else begin
                r_valid  <= 1'b1;
                r_ctrl   <= w_ctrl;
                r_port0  <= w_rdData0;
                r_port1  <= w_rdData1;
                r_rdReg1 <= w_rs;
                r_rdReg2 <= w_src2;
                r_wrReg  <= w_rd;
                r_shAmt  <= w_rt;
            end
        end
    end

    assign id_bus.o_stall    = w_stall_c;
    assign id_bus.o_valid    = r_valid;
    assign id_bus.o_port0    = r_port0;
    assign id_bus.o_port1    = r_port1;
    assign id_bus.o_rdReg1   = r_rdReg1;
    assign id_bus.o_rdReg2   = r_rdReg2;
    assign id_bus.o_wrReg    = r_wrReg;
    assign id_bus.o_rdReg1En = r_ctrl.rd1_en;
    assign id_bus.o_rdReg2En = r_ctrl.rd2_en;
    assign id_bus.o_wrRegEn  = r_ctrl.wr_en;
    assign id_bus.o_aluOp    = r_ctrl.alu_op;
    assign id_bus.o_shAmt    = r_shAmt;
    assign id_bus.o_aluSrc   = r_ctrl.alu_src;
    assign id_bus.o_memRd    = r_ctrl.mem_rd;
    assign id_bus.o_memWr    = r_ctrl.mem_wr;
    assign id_bus.o_mem2reg  = r_ctrl.mem_rd;
    assign id_bus.o_sawBr    = r_ctrl.saw_br;
    assign id_bus.o_sawJ     = r_ctrl.saw_j;
    assign id_bus.o_hlt      = r_ctrl.hlt;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe; instruction = opcode|rd|rs|rt, 4 bits each.
module tb_id_stage_pipe;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    id_stage_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .i_clk  (clk),
        .i_nRst (rst_n),
        .id_bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] instr, input logic v, input logic fl);
        bus.i_instr      = instr;
        bus.i_instrValid = v;
        bus.i_flush      = fl;
    endtask

    task automatic wb(input logic en, input logic [3:0] a, input logic [15:0] d);
        bus.i_wrEn   = en;
        bus.i_wrReg  = a;
        bus.i_wrData = d;
    endtask

    task automatic test_reset();
        #2;
        n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %h exp 0", bus.o_valid); end
        n_vec++; if (bus.o_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %h exp 0", bus.o_stall); end
        n_vec++; if ({bus.o_aluSrc, bus.o_memRd, bus.o_memWr, bus.o_mem2reg, bus.o_sawBr, bus.o_sawJ, bus.o_hlt,
                      bus.o_rdReg1En, bus.o_rdReg2En, bus.o_wrRegEn} !== 10'b0)
            begin n_err++; $display("FAIL rst_ctrl got nonzero control exp 0"); end
        n_vec++; if ({bus.o_port0, bus.o_port1} !== 32'h0) begin n_err++; $display("FAIL rst_ports got %h exp 0", {bus.o_port0, bus.o_port1}); end
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_writeback_read();
        wb(1'b1, 4'd1, 16'h0055); step();
        wb(1'b1, 4'd5, 16'h0005); step();
        wb(1'b1, 4'd3, 16'h1234); step();
        wb(1'b0, 4'd0, 16'h0000);
        drive(16'h0133, 1'b1, 1'b0);  // ADD R1,R3,R3
        #1;
        n_vec++; if (bus.o_stall !== 1'b0) begin n_err++; $display("FAIL add_stall got %h exp 0", bus.o_stall); end
        step();
        n_vec++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %h exp 1", bus.o_valid); end
        n_vec++; if ({bus.o_port0, bus.o_port1} !== 32'h1234_1234) begin n_err++; $display("FAIL add_ports got %h exp 12341234", {bus.o_port0, bus.o_port1}); end
        n_vec++; if ({bus.o_rdReg1, bus.o_rdReg2, bus.o_wrReg} !== 12'h331) begin n_err++; $display("FAIL add_addrs got %h exp 331", {bus.o_rdReg1, bus.o_rdReg2, bus.o_wrReg}); end
        n_vec++; if ({bus.o_rdReg1En, bus.o_rdReg2En, bus.o_wrRegEn, bus.o_aluSrc, bus.o_memRd, bus.o_memWr} !== 6'b111000)
            begin n_err++; $display("FAIL add_ctrl got %b exp 111000", {bus.o_rdReg1En, bus.o_rdReg2En, bus.o_wrRegEn, bus.o_aluSrc, bus.o_memRd, bus.o_memWr}); end
    endtask

    task automatic test_load_use();
        drive(16'h8210, 1'b1, 1'b0);  // LW R2,R1
        step();
        n_vec++; if ({bus.o_valid, bus.o_aluSrc, bus.o_memRd, bus.o_memWr, bus.o_mem2reg} !== 5'b11101)
            begin n_err++; $display("FAIL lw_ctrl got %b exp 11101", {bus.o_valid, bus.o_aluSrc, bus.o_memRd, bus.o_memWr, bus.o_mem2reg}); end
        n_vec++; if ({bus.o_wrReg, bus.o_port0} !== 20'h2_0055) begin n_err++; $display("FAIL lw_dest got %h exp 20055", {bus.o_wrReg, bus.o_port0}); end
        drive(16'h1425, 1'b1, 1'b0);  // SUB R4,R2,R5
        #1;
        n_vec++; if (bus.o_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %h exp 1", bus.o_stall); end
        step();
        n_vec++; if ({bus.o_valid, bus.o_wrRegEn, bus.o_memRd} !== 3'b000) begin n_err++; $display("FAIL lu_bubble got %b exp 000", {bus.o_valid, bus.o_wrRegEn, bus.o_memRd}); end
        n_vec++; if (bus.o_stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_drop got %h exp 0", bus.o_stall); end
        step();
        n_vec++; if ({bus.o_valid, bus.o_aluOp, bus.o_rdReg1, bus.o_rdReg2, bus.o_wrReg} !== 17'h1_1254)
            begin n_err++; $display("FAIL lu_issue got %h exp 11254", {bus.o_valid, bus.o_aluOp, bus.o_rdReg1, bus.o_rdReg2, bus.o_wrReg}); end
        n_vec++; if (bus.o_port1 !== 16'h0005) begin n_err++; $display("FAIL lu_port1 got %h exp 0005", bus.o_port1); end
    endtask

    task automatic test_flush_hazard();
        drive(16'h8210, 1'b1, 1'b0);
        step();
        drive(16'h1425, 1'b1, 1'b1);
        #1;
        n_vec++; if (bus.o_stall !== 1'b0) begin n_err++; $display("FAIL fl_stall got %h exp 0", bus.o_stall); end
        step();
        n_vec++; if ({bus.o_valid, bus.o_rdReg1En, bus.o_rdReg2En, bus.o_wrRegEn} !== 4'b0000)
            begin n_err++; $display("FAIL fl_bubble got %b exp 0000", {bus.o_valid, bus.o_rdReg1En, bus.o_rdReg2En, bus.o_wrRegEn}); end
        drive(16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_r0_imm();
        wb(1'b1, 4'd0, 16'hFFFF); step();
        wb(1'b0, 4'd0, 16'h0000);
        drive(16'h0700, 1'b1, 1'b0);  // ADD R7,R0,R0
        step();
        n_vec++; if ({bus.o_valid, bus.o_port0, bus.o_port1} !== 33'h0_0000_0000 + 33'h1_0000_0000)
            begin n_err++; $display("FAIL r0_read got %h exp 100000000", {bus.o_valid, bus.o_port0, bus.o_port1}); end
        drive(16'hA909, 1'b1, 1'b0);  // ADDI R9,R0,9
        step();
        n_vec++; if ({bus.o_aluSrc, bus.o_shAmt, bus.o_wrReg, bus.o_rdReg1En, bus.o_rdReg2En, bus.o_wrRegEn} !== 12'b1_1001_1001_101)
            begin n_err++; $display("FAIL addi_ctrl got %b exp 110011001101", {bus.o_aluSrc, bus.o_shAmt, bus.o_wrReg, bus.o_rdReg1En, bus.o_rdReg2En, bus.o_wrRegEn}); end
    endtask

    task automatic test_store_branch_hold();
        drive(16'h9310, 1'b1, 1'b0);  // SW R3 -> [R1]
        step();
        n_vec++; if ({bus.o_aluSrc, bus.o_memRd, bus.o_memWr, bus.o_rdReg1En, bus.o_rdReg2En, bus.o_wrRegEn, bus.o_rdReg2} !== 10'b101_110_0011)
            begin n_err++; $display("FAIL sw_ctrl got %b exp 1011100011", {bus.o_aluSrc, bus.o_memRd, bus.o_memWr, bus.o_rdReg1En, bus.o_rdReg2En, bus.o_wrRegEn, bus.o_rdReg2}); end
        n_vec++; if ({bus.o_port0, bus.o_port1} !== 32'h0055_1234) begin n_err++; $display("FAIL sw_ports got %h exp 00551234", {bus.o_port0, bus.o_port1}); end
        bus.i_Z = 1'b1;
        drive(16'hB000, 1'b1, 1'b0);
        step();
        bus.i_Z = 1'b0;
        n_vec++; if ({bus.o_valid, bus.o_sawBr, bus.o_rdReg1En, bus.o_rdReg2En} !== 4'b1100) begin n_err++; $display("FAIL br_ctrl got %b exp 1100", {bus.o_valid, bus.o_sawBr, bus.o_rdReg1En, bus.o_rdReg2En}); end
        drive(16'hC030, 1'b1, 1'b0);  // JR R3
        step();
        n_vec++; if ({bus.o_sawJ, bus.o_rdReg1En, bus.o_port0} !== 18'b11_0001_0010_0011_0100) begin n_err++; $display("FAIL jr_ctrl got %h exp 31234", {bus.o_sawJ, bus.o_rdReg1En, bus.o_port0}); end
        bus.i_hlt = 1'b1;
        drive(16'h0133, 1'b1, 1'b0);
        step(); step();
        n_vec++; if ({bus.o_valid, bus.o_sawJ, bus.o_wrRegEn} !== 3'b110) begin n_err++; $display("FAIL hold_regs got %b exp 110", {bus.o_valid, bus.o_sawJ, bus.o_wrRegEn}); end
        bus.i_hlt = 1'b0;
        step();
        n_vec++; if ({bus.o_valid, bus.o_sawJ, bus.o_wrRegEn} !== 3'b101) begin n_err++; $display("FAIL hold_release got %b exp 101", {bus.o_valid, bus.o_sawJ, bus.o_wrRegEn}); end
    endtask

    task automatic test_wb_clash();
        drive(16'h0000, 1'b0, 1'b0);
        wb(1'b1, 4'd6, 16'h1111); step();
        wb(1'b1, 4'd6, 16'h2222);
        drive(16'h0860, 1'b1, 1'b0);  // ADD R8,R6,R0
        #1;
`ifdef ID_WR_BYPASS_EN
        n_vec++; if (bus.o_stall !== 1'b0) begin n_err++; $display("FAIL clash_stall got %h exp 0", bus.o_stall); end
        step();
        wb(1'b0, 4'd0, 16'h0000);
`else
        n_vec++; if (bus.o_stall !== 1'b1) begin n_err++; $display("FAIL clash_stall got %h exp 1", bus.o_stall); end
        step();
        n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL clash_bubble got %h exp 0", bus.o_valid); end
        wb(1'b0, 4'd0, 16'h0000);
        #1;
        n_vec++; if (bus.o_stall !== 1'b0) begin n_err++; $display("FAIL clash_stall_drop got %h exp 0", bus.o_stall); end
        step();
`endif
        n_vec++; if ({bus.o_valid, bus.o_port0} !== 17'h1_2222) begin n_err++; $display("FAIL clash_read got %h exp 12222", {bus.o_valid, bus.o_port0}); end
    endtask

    task automatic test_halt();
        drive(16'hF000, 1'b1, 1'b0);
        step();
        n_vec++; if ({bus.o_valid, bus.o_hlt} !== 2'b11) begin n_err++; $display("FAIL hlt_issue got %b exp 11", {bus.o_valid, bus.o_hlt}); end
        drive(16'h0133, 1'b1, 1'b0);
        step();
        n_vec++; if ({bus.o_valid, bus.o_hlt} !== 2'b00) begin n_err++; $display("FAIL hlt_bubble1 got %b exp 00", {bus.o_valid, bus.o_hlt}); end
        step();
        n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL hlt_bubble2 got %h exp 0", bus.o_valid); end
        rst_n = 1'b0; #1; rst_n = 1'b1;
        step();
        n_vec++; if ({bus.o_valid, bus.o_wrReg} !== 5'b1_0001) begin n_err++; $display("FAIL hlt_after_rst got %b exp 10001", {bus.o_valid, bus.o_wrReg}); end
    endtask

    task automatic test_reset_mid();
        drive(16'h8210, 1'b1, 1'b0);
        step();
        drive(16'h1425, 1'b1, 1'b0);
        #1;
        n_vec++; if (bus.o_stall !== 1'b1) begin n_err++; $display("FAIL mid_pre_stall got %h exp 1", bus.o_stall); end
        rst_n = 1'b0;
        #1;
        n_vec++; if ({bus.o_valid, bus.o_stall, bus.o_memRd, bus.o_wrRegEn, bus.o_wrReg} !== 8'h00)
            begin n_err++; $display("FAIL mid_rst got %h exp 00", {bus.o_valid, bus.o_stall, bus.o_memRd, bus.o_wrRegEn, bus.o_wrReg}); end
        drive(16'h0000, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        drive(16'h0000, 1'b0, 1'b0);
        wb(1'b0, 4'd0, 16'h0000);
        bus.i_hlt = 1'b0;
        bus.i_Z   = 1'b0;
        test_reset();
        test_writeback_read();
        test_load_use();
        test_flush_hazard();
        test_r0_imm();
        test_store_branch_hold();
        test_wb_clash();
        test_halt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
